// File: rtl/proc_defs.sv
// proc_defs: opcode classes, instruction field positions and sequencer state encoding
package proc_defs;
  localparam logic [3:0] OP_ADD = 4'h0, OP_1 = 4'h1, OP_2 = 4'h2, OP_3 = 4'h3;
  localparam logic [3:0] OP_4 = 4'h4, OP_5 = 4'h5, OP_6 = 4'h6, OP_HALT = 4'hF;
  localparam int CODOP_HI = 15, CODOP_LO = 12, RC_HI = 11, RC_LO = 8;
  localparam int RA_HI = 7, RA_LO = 4, RB_HI = 3, RB_LO = 0;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, GAP, HALT} state_t;
  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_6 && op != OP_HALT;
  endfunction
endpackage

// File: rtl/prog_mem.sv
// prog_mem: program store, single write port and registered read, no reset
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches program words and drives instr/exec with run, single-step and halt
module instr_sequencer
  import proc_defs::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int INSTR_W = 16,
  parameter int HOLD_CYCLES = 3
) (
  input  logic               CLOCK_50,
  input  logic               RST_N,
  input  logic               run,
  input  logic               step,
  input  logic               restart,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instr,
  output logic               exec,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               err
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  state_t state;
  logic step_q, step_rise, mem_we;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] pc_n, pc_inc;
  logic [INSTR_W-1:0] word;
  logic [3:0] op;
  always_comb begin
    step_rise = step & ~step_q;
    op = word[CODOP_HI:CODOP_LO];
    mem_we = prog_we && (state == IDLE || state == HALT);
    pc_inc = (pc == ADDR_W'(PROG_DEPTH - 1)) ? '0 : pc + ADDR_W'(1);
    pc_n = restart ? '0 : ((state == FETCH && is_illegal(op)) || state == GAP) ? pc_inc : pc;
  end
  // read address is the next pc so the word at pc is ready during the single FETCH cycle
  prog_mem #(.DEPTH(PROG_DEPTH), .AW(ADDR_W), .DW(INSTR_W)) u_mem (
    .clk(CLOCK_50), .we(mem_we), .waddr(prog_addr), .wdata(prog_data),
    .raddr(pc_n), .rdata(word)
  );
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      pc <= '0;
      instr <= '0;
      exec <= 1'b0;
      busy <= 1'b0;
      halted <= 1'b0;
      err <= 1'b0;
      step_q <= 1'b0;
      cnt <= '0;
    end else begin
      step_q <= step;
      pc <= pc_n;
      if (restart) begin
        state <= IDLE;
        exec <= 1'b0;
        busy <= 1'b0;
        halted <= 1'b0;
      end else begin
        case (state)
          IDLE: if (run || step_rise) begin
            state <= FETCH;
            busy <= 1'b1;
          end
          FETCH: if (op == OP_HALT) begin
            state <= HALT;
            busy <= 1'b0;
            halted <= 1'b1;
          end else if (is_illegal(op)) begin
            err <= 1'b1;
            state <= run ? FETCH : IDLE;
            busy <= run;
          end else begin
            instr <= word;
            exec <= 1'b1;
            cnt <= '0;
            state <= ISSUE;
          end
          ISSUE: if (cnt == CW'(HOLD_CYCLES - 1)) begin
            exec <= 1'b0;
            state <= GAP;
          end else cnt <= cnt + CW'(1);
          GAP: begin
            state <= run ? FETCH : IDLE;
            busy <= run;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: table-driven trace plus directed multi-cycle checks of instr_sequencer
module tb_instr_sequencer;
  logic CLOCK_50 = 1'b0, RST_N = 1'b0;
  logic run = 0, step = 0, restart = 0, prog_we = 0;
  logic [3:0] prog_addr = '0, pc;
  logic [15:0] prog_data = '0, instr;
  logic exec, busy, halted, err;
  int nvec = 0, nerr = 0;
  int pulses = 0, width = 0, bad_width = 0;
  logic exec_d = 1'b0;
  logic [15:0] last_instr = '0;

  instr_sequencer dut (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N), .run(run), .step(step), .restart(restart),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(instr), .exec(exec), .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (exec && !exec_d) begin
      pulses++;
      last_instr = instr;
    end
    if (exec) width++;
    else begin
      if (exec_d && width != 3) bad_width++;
      width = 0;
    end
    exec_d = exec;
  end

  typedef struct {
    logic r, s, rs, w;
    logic [3:0] a;
    logic [15:0] d;
    logic [15:0] ei;
    logic ee;
    logic [3:0] ep;
    logic eb, eh, er;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, s, rs, w, input logic [3:0] a, input logic [15:0] d,
                     input logic [15:0] ei, input logic ee, input logic [3:0] ep,
                     input logic eb, eh, er);
    tbl.push_back('{r, s, rs, w, a, d, ei, ee, ep, eb, eh, er});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse_restart();
    restart = 1;
    cyc(1);
    restart = 0;
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1;
    prog_addr = a;
    prog_data = d;
    cyc(1);
    prog_we = 0;
  endtask

  task automatic wait_exec(input string nm);
    int n = 0;
    while (!exec && n < 40) begin
      cyc(1);
      n++;
    end
    chk(nm, 32'(exec), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 40) begin
      cyc(1);
      n++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic do_step();
    step = 1;
    cyc(10);
    step = 0;
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, n;
    logic s15, wrapped;
    //  r s rs w  a   data    | instr   ex pc b h e
    add(0, 0, 0, 1, 0, 16'h0123, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 16'h1456, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2, 16'h2789, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 3, 16'hF000, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 16'h0123, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0123, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0123, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 16'h1456, 1, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h1456, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h1456, 0, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 16'h2789, 1, 2, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h2789, 0, 2, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h2789, 0, 3, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h2789, 0, 3, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 16'h2789, 0, 3, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 16'h2789, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h2789, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h0123, 1, 0, 1, 0, 0);
    add(0, 1, 0, 1, 2, 16'h0AAA, 16'h0123, 1, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h0123, 1, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h0123, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h0123, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 16'h0123, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h0123, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 16'h1456, 1, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h1456, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h1456, 0, 2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h1456, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 16'h1456, 0, 2, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h1456, 0, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 16'h2789, 1, 2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h2789, 0, 2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h2789, 0, 3, 0, 0, 0);
    add(0, 0, 0, 1, 2, 16'h0AAA, 16'h2789, 0, 3, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 16'h2789, 0, 0, 0, 0, 0);

    cyc(2);
    chk("reset_state", 32'({instr, exec, pc, busy, halted, err}), 32'd0);
    RST_N = 1;
    foreach (tbl[i]) begin
      run = tbl[i].r;
      step = tbl[i].s;
      restart = tbl[i].rs;
      prog_we = tbl[i].w;
      prog_addr = tbl[i].a;
      prog_data = tbl[i].d;
      cyc(1);
      chk($sformatf("vec%0d", i), 32'({instr, exec, pc, busy, halted, err}),
          32'({tbl[i].ei, tbl[i].ee, tbl[i].ep, tbl[i].eb, tbl[i].eh, tbl[i].er}));
    end
    {run, step, restart, prog_we} = '0;

    p0 = pulses;
    do_step();
    chk("step1_pc", 32'(pc), 32'd1);
    do_step();
    chk("step2_pc", 32'(pc), 32'd2);
    chk("step2_instr", 32'(last_instr), 32'h1456);
    do_step();
    chk("step3_pc", 32'(pc), 32'd3);
    chk("idle_write_instr", 32'(last_instr), 32'h0AAA);
    chk("step_pulses", 32'(pulses - p0), 32'd3);

    pulse_restart();
    for (int i = 0; i < 16; i++) write(4'(i), 16'h0111);
    p0 = pulses;
    s15 = 0;
    wrapped = 0;
    run = 1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (pc == 4'd15) s15 = 1;
      if (s15 && pc == 4'd0) wrapped = 1;
    end
    n = pulses - p0;
    run = 0;
    chk("wrap_pulse_count", 32'(n >= 19 && n <= 21), 32'd1);
    wait_idle("wrap_idle");
    chk("wrap_pc_wrapped", 32'(wrapped), 32'd1);
    chk("wrap_err", 32'(err), 32'd0);
    chk("exec_width", 32'(bad_width), 32'd0);

    pulse_restart();
    write(4'd0, 16'h0222);
    run = 1;
    n = 0;
    while (!(exec && pc == 4'd2) && n < 60) begin
      cyc(1);
      n++;
    end
    chk("reach_pc2_exec", 32'(exec && pc == 4'd2), 32'd1);
    cyc(1);
    #5 RST_N = 0;
    #1 chk("async_reset", 32'({instr, exec, pc, busy, halted}), 32'd0);
    cyc(1);
    RST_N = 1;
    wait_exec("post_reset_exec");
    chk("post_reset_instr", 32'(instr), 32'h0222);
    chk("post_reset_pc", 32'(pc), 32'd0);
    run = 0;
    wait_idle("post_reset_idle");

    pulse_restart();
    write(4'd0, 16'h7ABC);
    write(4'd1, 16'h0123);
    chk("err_before", 32'(err), 32'd0);
    run = 1;
    wait_exec("illegal_exec");
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_instr", 32'(instr), 32'h0123);
    chk("illegal_pc", 32'(pc), 32'd1);
    run = 0;
    wait_idle("illegal_idle");
    pulse_restart();
    chk("err_sticky", 32'(err), 32'd1);
    chk("restart_pc", 32'(pc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
